// File: rtl/slow_tick_receiver_if.sv
// Slow-tick receiver signal bundle: the slow input and the fast-domain strobes,
// period and status derived from it.
interface slow_tick_receiver_if #(
  parameter int unsigned CNT_W = 25
);
  logic             slow_in;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             lost;

  modport master (
    output slow_in,
    input  rise_pulse, fall_pulse, period, period_valid, locked, lost
  );

  modport slave (
    input  slow_in,
    output rise_pulse, fall_pulse, period, period_valid, locked, lost
  );
endinterface

// File: rtl/slow_tick_receiver.sv
// Synchronizes a slow clock-like signal into clk, emits rise/fall enables, measures the
// rising-to-rising period and tracks lock / loss of the slow signal.
module slow_tick_receiver #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 25,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned TOL         = 2,
  parameter int unsigned TIMEOUT     = 4194304
) (
  input logic                 clk,
  input logic                 rst_n,
  slow_tick_receiver_if.slave tick
);

  typedef enum logic [2:0] {StIdle, StMeasure, StAcquire, StLocked, StLost} state_e;

  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] Timeout = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] Tol     = CNT_W'(TOL);
  localparam logic [3:0]       LockCnt = 4'(LOCK_COUNT);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lvl_q;
  logic                   prev_q;
  logic                   rise_q;
  logic                   fall_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       ref_q;
  logic [CNT_W-1:0]       period_q;
  logic                   period_valid_q;
  logic                   locked_q;
  logic                   lost_q;
  logic [3:0]             mc_q;
  state_e                 state_q;

  logic [CNT_W-1:0] diff;
  logic             match;
  logic [3:0]       mc_inc;

  // Synchronizer, then a retimed level and its history; strobes are registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      lvl_q  <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tick.slow_in};
      lvl_q  <= sync_q[SYNC_STAGES-1];
      prev_q <= lvl_q;
      rise_q <= lvl_q & ~prev_q;
      fall_q <= ~lvl_q & prev_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (rise_q) begin
      cnt_q <= CntOne;
    end else if (cnt_q != CntMax) begin
      cnt_q <= cnt_q + CntOne;
    end
  end

  always_comb begin
    diff   = (cnt_q >= ref_q) ? (cnt_q - ref_q) : (ref_q - cnt_q);
    match  = (diff <= Tol);
    mc_inc = mc_q + 4'd1;
  end

  // A mismatching period becomes the new reference so a shifted rate can relock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      mc_q           <= '0;
      ref_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      lost_q         <= 1'b0;
    end else begin
      period_valid_q <= 1'b0;
      if (rise_q) begin
        unique case (state_q)
          StIdle: begin
            state_q <= StMeasure;
          end
          StLost: begin
            state_q <= StMeasure;
            lost_q  <= 1'b0;
          end
          StMeasure: begin
            period_q       <= cnt_q;
            period_valid_q <= 1'b1;
            ref_q          <= cnt_q;
            mc_q           <= '0;
            state_q        <= StAcquire;
          end
          StAcquire: begin
            period_q       <= cnt_q;
            period_valid_q <= 1'b1;
            if (match) begin
              mc_q <= mc_inc;
              if (mc_inc == LockCnt) begin
                state_q  <= StLocked;
                locked_q <= 1'b1;
              end
            end else begin
              mc_q  <= '0;
              ref_q <= cnt_q;
            end
          end
          StLocked: begin
            period_q       <= cnt_q;
            period_valid_q <= 1'b1;
            if (!match) begin
              state_q  <= StAcquire;
              mc_q     <= '0;
              locked_q <= 1'b0;
              ref_q    <= cnt_q;
            end
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end else if ((cnt_q == Timeout) &&
                   (state_q inside {StMeasure, StAcquire, StLocked})) begin
        state_q  <= StLost;
        lost_q   <= 1'b1;
        locked_q <= 1'b0;
        mc_q     <= '0;
      end
    end
  end

  assign tick.rise_pulse   = rise_q;
  assign tick.fall_pulse   = fall_q;
  assign tick.period       = period_q;
  assign tick.period_valid = period_valid_q;
  assign tick.locked       = locked_q;
  assign tick.lost         = lost_q;

endmodule
